bus_mem_slave: RTL and testbench

- Word-addressed memory responder for the CPU external bus (W_* interface).
- It is the far end of the fetch unit's bus master port and serves the reads and writes the fetch unit issues to non-register addresses.
- It latches each request, inserts a configurable number of wait states, performs the access, then holds acknowledge until the master drops its strobe.
- It is used as the main-memory model in CPU benches and as the on-chip RAM in the SoC.

---
 rtl/bus_mem_slave.sv | 159 +++++++++++++++
 tb/tb_bus_mem_slave.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_mem_slave.sv
// bus_mem_slave: word-addressed memory responder on the W_* external bus.
// Accepts a strobed request in IDLE and latches address, direction and data.
// It then waits WAIT_STATES edges and performs the access. W_ACK is held
// until the master drops W_STB.
//
// Ports:
//   clk       bus clock, rising edge
//   rst       synchronous active-high reset
//   W_STB     request valid, held by master until W_ACK
//   W_WRITE   1 = write, 0 = read (sampled at accept)
//   W_ADDR    word address (sampled at accept)
//   W_DATA_I  write data (sampled at accept)
//   W_DATA_O  read data, valid while W_ACK is high on a read
//   W_ACK     transfer complete, level until W_STB falls
module bus_mem_slave #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_BITS   = 8,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  W_STB,
    input  logic                  W_WRITE,
    input  logic [31:0]           W_ADDR,
    input  logic [DATA_WIDTH-1:0] W_DATA_I,
    output logic [DATA_WIDTH-1:0] W_DATA_O,
    output logic                  W_ACK
);

    localparam int unsigned BUS_AW = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned DEPTH  = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [BUS_AW-1:0]       addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Access operands: live inputs on a zero-wait accept, latched copy otherwise.
    logic                    complete_c;
    logic [BUS_AW-1:0]       acc_addr_c;
    logic                    acc_write_c;
    logic [DATA_WIDTH-1:0]   acc_wdata_c;
    logic [ADDR_BITS-1:0]    acc_idx_c;
    logic                    acc_in_range_c;
    logic                    mem_we_c;

    // State and bus-side registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
        end
    end

    // Memory array is never cleared; reset only suppresses a write on that edge.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_c) begin
            mem[acc_idx_c] <= acc_wdata_c;
        end
    end

    // Next-state, request latching and access completion.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ack_d       = ack_q;
        rdata_d     = rdata_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        complete_c  = 1'b0;
        acc_addr_c  = addr_q;
        acc_write_c = write_q;
        acc_wdata_c = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (W_STB) begin
                    addr_d      = W_ADDR;
                    write_d     = W_WRITE;
                    wdata_d     = W_DATA_I;
                    acc_addr_c  = W_ADDR;
                    acc_write_c = W_WRITE;
                    acc_wdata_c = W_DATA_I;
                    if (WAIT_STATES == 0) begin
                        complete_c = 1'b1;
                        state_d    = ST_HOLD;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_STATES);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Abort takes priority over completion on the same edge.
                if (!W_STB) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    cnt_d      = '0;
                    complete_c = 1'b1;
                    state_d    = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!W_STB) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        acc_idx_c      = acc_addr_c[ADDR_BITS-1:0];
        acc_in_range_c = (acc_addr_c >> ADDR_BITS) == BUS_AW'(0);

        if (complete_c) begin
            ack_d = 1'b1;
            if (!acc_write_c) begin
                rdata_d = acc_in_range_c ? mem[acc_idx_c] : '0;
            end
        end

        mem_we_c = complete_c && acc_write_c && acc_in_range_c;
    end

    assign W_ACK    = ack_q;
    assign W_DATA_O = rdata_q;

endmodule

// File: tb/tb_bus_mem_slave.sv
// Bench for bus_mem_slave: three instances (0, 2 and 3 wait states) driven
// by directed and random transfers, checked against an array memory model.
module tb_bus_mem_slave;

    localparam int unsigned NI = 3;

    logic        clk;
    logic        rst;
    logic        stb   [NI];
    logic        wr    [NI];
    logic [31:0] addr  [NI];
    logic [31:0] wdi   [NI];
    logic [31:0] wdo   [NI];
    logic        ack   [NI];

    int checks;
    int failures;

    logic [31:0] mem_m   [NI][256];
    logic [31:0] last_rd [NI];

    bus_mem_slave #(.DATA_WIDTH(32), .ADDR_BITS(8), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .W_STB(stb[0]), .W_WRITE(wr[0]), .W_ADDR(addr[0]),
        .W_DATA_I(wdi[0]), .W_DATA_O(wdo[0]), .W_ACK(ack[0]));
    bus_mem_slave #(.DATA_WIDTH(32), .ADDR_BITS(8), .WAIT_STATES(2)) u_ws2 (
        .clk(clk), .rst(rst), .W_STB(stb[1]), .W_WRITE(wr[1]), .W_ADDR(addr[1]),
        .W_DATA_I(wdi[1]), .W_DATA_O(wdo[1]), .W_ACK(ack[1]));
    bus_mem_slave #(.DATA_WIDTH(32), .ADDR_BITS(8), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .W_STB(stb[2]), .W_WRITE(wr[2]), .W_ADDR(addr[2]),
        .W_DATA_I(wdi[2]), .W_DATA_O(wdo[2]), .W_ACK(ack[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input int i);
        case (i)
            0:       return 0;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transfer, called at a negedge; returns at the negedge after ACK falls.
    task automatic do_xfer(input int i, input bit w, input logic [31:0] a,
                           input logic [31:0] d, input int hold, input bit chg);
        int          ws;
        bit          inr;
        logic [7:0]  idx;
        ws  = ws_of(i);
        inr = (a >> 8) == 32'd0;
        idx = a[7:0];
        stb[i] = 1'b1; wr[i] = w; addr[i] = a; wdi[i] = d;
        // ACK must rise exactly ws edges after the accept edge.
        for (int c = 0; c <= ws; c++) begin
            @(negedge clk);
            if (chg) begin
                addr[i] = $urandom; wdi[i] = $urandom; wr[i] = 1'($urandom_range(0, 1));
            end
            check($sformatf("ack_latency i%0d c%0d", i, c), 32'(ack[i]), 32'(c == ws));
        end
        if (w) begin
            if (inr) mem_m[i][idx] = d;
        end else begin
            last_rd[i] = inr ? mem_m[i][idx] : 32'd0;
        end
        check($sformatf("%s i%0d a%h", w ? "wr_dout_kept" : "rd_data", i, a), wdo[i], last_rd[i]);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (chg) begin
                addr[i] = $urandom; wdi[i] = $urandom; wr[i] = 1'($urandom_range(0, 1));
            end
            check($sformatf("ack_hold i%0d", i), 32'(ack[i]), 32'd1);
            check($sformatf("dout_hold i%0d", i), wdo[i], last_rd[i]);
        end
        stb[i] = 1'b0;
        @(negedge clk);
        check($sformatf("ack_fall i%0d", i), 32'(ack[i]), 32'd0);
        check($sformatf("dout_after i%0d", i), wdo[i], last_rd[i]);
    endtask

    // Write dropped before completion; edge k+1+drop_at sees STB low.
    task automatic do_abort(input int i, input logic [31:0] a, input logic [31:0] d,
                            input int drop_at);
        int ws;
        ws = ws_of(i);
        stb[i] = 1'b1; wr[i] = 1'b1; addr[i] = a; wdi[i] = d;
        for (int c = 0; c <= drop_at; c++) begin
            @(negedge clk);
            check($sformatf("abort_pre i%0d", i), 32'(ack[i]), 32'd0);
        end
        stb[i] = 1'b0;
        for (int c = 0; c <= ws + 1; c++) begin
            @(negedge clk);
            check($sformatf("abort_noack i%0d", i), 32'(ack[i]), 32'd0);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            stb[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdi[i] = '0; last_rd[i] = '0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_ack i%0d", i), 32'(ack[i]), 32'd0);
            check($sformatf("reset_dout i%0d", i), wdo[i], 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);

        // Fill every word of every instance so later reads are defined.
        for (int i = 0; i < NI; i++)
            for (int a = 0; a < 256; a++)
                do_xfer(i, 1'b1, 32'(a), $urandom, 0, 1'b0);

        // Zero-wait write held for several cycles, then read back.
        do_xfer(0, 1'b1, 32'h10, 32'h1111_1111, 3, 1'b0);
        do_xfer(0, 1'b0, 32'h10, 32'h0, 1, 1'b0);
        check("ws0_readback", wdo[0], 32'h1111_1111);

        // Two wait states; address and data change during WAIT are ignored.
        do_xfer(1, 1'b1, 32'h11, 32'h2222_2222, 0, 1'b0);
        do_xfer(1, 1'b1, 32'h10, 32'h3333_3333, 0, 1'b0);
        do_xfer(1, 1'b0, 32'h11, 32'h0, 2, 1'b1);
        check("ws2_read_latched", wdo[1], 32'h2222_2222);

        // Aborted write leaves memory untouched.
        do_xfer(2, 1'b1, 32'h05, 32'h0, 0, 1'b0);
        do_abort(2, 32'h05, 32'hAAAA_5555, 0);
        do_xfer(2, 1'b0, 32'h05, 32'h0, 0, 1'b0);
        check("abort_mem_kept", wdo[2], 32'h0);
        do_abort(1, 32'h05, 32'hAAAA_5555, 1);
        do_abort(2, 32'h05, 32'hAAAA_5555, 2);

        // Out-of-range accesses acknowledged, writes dropped, reads zero.
        for (int i = 0; i < NI; i++) begin
            do_xfer(i, 1'b1, 32'h05, 32'h0505_0505, 0, 1'b0);
            do_xfer(i, 1'b1, 32'h0000_0105, 32'hDEAD_BEEF, 0, 1'b0);
            do_xfer(i, 1'b0, 32'h05, 32'h0, 0, 1'b0);
            check($sformatf("oor_wr_dropped i%0d", i), wdo[i], 32'h0505_0505);
            do_xfer(i, 1'b0, 32'h0000_0105, 32'h0, 0, 1'b0);
            check($sformatf("oor_rd_zero i%0d", i), wdo[i], 32'h0);
        end

        // Reset during WAIT of a write abandons it.
        do_xfer(2, 1'b1, 32'h07, 32'h0707_0707, 0, 1'b0);
        do_xfer(2, 1'b0, 32'h07, 32'h0, 0, 1'b0);
        stb[2] = 1'b1; wr[2] = 1'b1; addr[2] = 32'h07; wdi[2] = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("midrst_ack i%0d", i), 32'(ack[i]), 32'd0);
            check($sformatf("midrst_dout i%0d", i), wdo[i], 32'd0);
            last_rd[i] = 32'd0;
        end
        rst = 1'b0;
        stb[2] = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("midrst_noack", 32'(ack[2]), 32'd0);
        end
        do_xfer(2, 1'b0, 32'h07, 32'h0, 0, 1'b0);
        check("midrst_old_value", wdo[2], 32'h0707_0707);

        // Back-to-back: STB held through HOLD with address churn, then re-accept.
        for (int i = 0; i < NI; i++) begin
            do_xfer(i, 1'b0, 32'h20, 32'h0, 3, 1'b1);
            do_xfer(i, 1'b1, 32'h21, 32'hCAFE_0000 + 32'(i), 0, 1'b0);
            do_xfer(i, 1'b0, 32'h21, 32'h0, 0, 1'b0);
            check($sformatf("b2b_readback i%0d", i), wdo[i], 32'hCAFE_0000 + 32'(i));
        end

        // Random mixed traffic.
        for (int n = 0; n < 300; n++) begin
            int          i;
            logic [31:0] a;
            i = int'($urandom_range(0, NI - 1));
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 7) == 0) a = a | ($urandom & 32'hFFFF_FF00);
            if (ws_of(i) > 0 && $urandom_range(0, 9) == 0)
                do_abort(i, a, $urandom, int'($urandom_range(0, ws_of(i) - 1)));
            else
                do_xfer(i, 1'($urandom_range(0, 1)), a, $urandom,
                        int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
